// File: rtl/xbar_slave_session_ctrl.sv
// xbar_slave_session_ctrl: per-slave cross-bar session controller.
// It latches the arbiter's one-hot grant and muxes the granted master's request onto the slave port.
// It routes ack, resp and rdata back to that master only, and pulses i/o session_done when the session closes.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   i_grant                           one-hot grant from the arbiter
//   i_m_req/i_m_addr/i_m_cmd/i_m_wdata  packed master requests (master i at slice i)
//   o_m_ack/o_m_resp/o_m_rdata        responses routed to the selected master
//   o_s_req/o_s_addr/o_s_cmd/o_s_wdata  request to the slave
//   i_s_ack/i_s_resp/i_s_rdata        slave handshake and read data
//   o_session_done                    1-cycle pulse, the arbiter may re-grant
//   o_timeout_err                     1-cycle pulse with o_session_done on abort
//   o_grant_err                       sticky flag for a non-one-hot grant
module xbar_slave_session_ctrl #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          i_grant,
  input  logic [N_MASTERS-1:0]          i_m_req,
  input  logic [N_MASTERS*ADDR_W-1:0]   i_m_addr,
  input  logic [N_MASTERS-1:0]          i_m_cmd,
  input  logic [N_MASTERS*DATA_W-1:0]   i_m_wdata,
  output logic [N_MASTERS-1:0]          o_m_ack,
  output logic [N_MASTERS-1:0]          o_m_resp,
  output logic [DATA_W-1:0]             o_m_rdata,
  output logic                          o_s_req,
  output logic [ADDR_W-1:0]             o_s_addr,
  output logic                          o_s_cmd,
  output logic [DATA_W-1:0]             o_s_wdata,
  input  logic                          i_s_ack,
  input  logic                          i_s_resp,
  input  logic [DATA_W-1:0]             i_s_rdata,
  output logic                          o_session_done,
  output logic                          o_timeout_err,
  output logic                          o_grant_err
);
  localparam int SW = $clog2(N_MASTERS);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_WAIT_RESP} state_t;
  state_t r_state, w_next;
  logic [SW-1:0] r_sel, w_lo;
  logic [TW-1:0] r_timer;
  logic [N_MASTERS-1:0] w_oh;
  logic r_done, r_tmo, r_gerr;
  logic w_wa, w_wr, w_start, w_ack, w_expire, w_abort;
  always_comb begin
    w_lo = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) if (i_grant[i]) w_lo = SW'(i);
  end
  // While the done pulse is out the arbiter is still dropping the old grant, so grant is ignored.
  assign w_start = r_state == S_IDLE && !r_done && |i_grant;
  assign w_wa = r_state == S_WAIT_ACK;
  assign w_wr = r_state == S_WAIT_RESP;
  assign w_oh = N_MASTERS'(1) << r_sel;
  assign w_ack = w_wa && i_s_ack && i_m_req[r_sel];
  assign w_expire = TIMEOUT != 0 && (w_wa || w_wr) && r_timer == TW'(TIMEOUT - 1);
  // A handshake landing on the expiry cycle completes normally.
  assign w_abort = w_expire && !(w_ack || (w_wr && i_s_resp));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == S_IDLE ? (w_start ? S_WAIT_ACK : S_IDLE)
           : w_wa ? (w_ack ? (i_m_cmd[r_sel] ? S_IDLE : S_WAIT_RESP) : (w_abort ? S_IDLE : S_WAIT_ACK))
           : w_wr ? (i_s_resp || w_abort ? S_IDLE : S_WAIT_RESP)
           : S_IDLE;
  always_comb begin
    o_s_req   = w_wa & i_m_req[r_sel];
    o_s_addr  = w_wa ? i_m_addr[r_sel*ADDR_W +: ADDR_W] : '0;
    o_s_cmd   = w_wa & i_m_cmd[r_sel];
    o_s_wdata = w_wa ? i_m_wdata[r_sel*DATA_W +: DATA_W] : '0;
    o_m_ack   = w_ack ? w_oh : '0;
    o_m_resp  = (w_wr && i_s_resp) || w_abort ? w_oh : '0;
    o_m_rdata = w_abort ? ERR_DATA : w_wr ? i_s_rdata : '0;
    o_session_done = r_done;
    o_timeout_err  = r_tmo;
    o_grant_err    = r_gerr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sel   <= '0;
      r_timer <= '0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
      r_gerr  <= 1'b0;
    end else begin
      r_sel   <= w_start ? w_lo : r_sel;
      r_timer <= r_state == S_IDLE ? '0 : (&r_timer ? r_timer : r_timer + 1'b1);
      r_done  <= r_state != S_IDLE && w_next == S_IDLE;
      r_tmo   <= w_abort;
      r_gerr  <= r_gerr | (w_start && |(i_grant & (i_grant - 1'b1)));
    end
endmodule
